// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data memory responder: FSM state encoding,
// access-width encoding and default window geometry.
package data_mem_responder_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam logic BYTE = 1'b1;
  localparam logic WORD = 1'b0;

  localparam logic [15:0] RAM_BASE       = 16'h0200;
  localparam int          RAM_SIZE_WORDS = 256;

  // Place a byte into the lane selected by the low address bit.
  function automatic logic [15:0] lane_place(input logic odd, input logic [7:0] b);
    if (odd) begin
      lane_place = {b, 8'h00};
    end else begin
      lane_place = {8'h00, b};
    end
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU system-bus signals seen by a memory responder.
interface data_mem_responder_if;
  logic [15:0] MAB;
  logic [15:0] MDBout;
  logic        BW;
  logic        MW;
  logic [15:0] MDBin;

  modport master (output MAB, output MDBout, output BW, output MW, input MDBin);
  modport slave  (input MAB, input MDBout, input BW, input MW, output MDBin);
endinterface

// File: rtl/data_mem_responder_ram_word_array.sv
// Word-organised storage with independent byte-lane write enables and an
// asynchronous read port. Contents are deliberately not reset.
module data_mem_responder_ram_word_array #(
  parameter int WORDS = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             we_lo,
  input  logic             we_hi,
  input  logic [IDX_W-1:0] widx,
  input  logic [15:0]      wdata,
  input  logic [IDX_W-1:0] ridx,
  output logic [15:0]      rdata
);

  logic [15:0] mem_r [WORDS];

  // Byte-lane write port.
  always_ff @(posedge clk) begin
    if (we_lo) begin
      mem_r[widx][7:0] <= wdata[7:0];
    end
    if (we_hi) begin
      mem_r[widx][15:8] <= wdata[15:8];
    end
  end

  assign rdata = mem_r[ridx];

endmodule

// File: rtl/data_mem_responder.sv
// Memory-side bus responder: window decode, zero-fill FSM after reset,
// byte-lane write merging, lane-steered reads and sticky write-while-busy flag.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter logic [15:0] BASE           = RAM_BASE,
  parameter int          SIZE_WORDS     = RAM_SIZE_WORDS,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus,
  input  logic                 ViolClr,
  output logic                 busy,
  output logic                 ViolFlag,
  output logic [15:0]          ViolAddr
);

  localparam int          IDX_W   = $clog2(SIZE_WORDS);
  localparam logic [16:0] BASE_X  = {1'b0, BASE};
  localparam logic [16:0] LIMIT_X = BASE_X + 17'(2 * SIZE_WORDS);

  if ((BASE[0] != 1'b0) || (LIMIT_X > 17'h10000) || (SIZE_WORDS < 2) ||
      ((SIZE_WORDS & (SIZE_WORDS - 1)) != 0)) begin : g_bad_geometry
    $error("data_mem_responder: illegal BASE/SIZE_WORDS combination");
  end

  state_t           state_r, state_nxt_s;
  logic [IDX_W-1:0] cnt_r, cnt_nxt_s;
  logic             sel_s;
  logic [15:0]      off_s;
  logic [IDX_W-1:0] idx_s;
  logic             we_lo_s, we_hi_s;
  logic [IDX_W-1:0] widx_s;
  logic [15:0]      wdata_s;
  logic [15:0]      rdata_s;
  logic [15:0]      mdbin_s;
  logic             viol_s;
  logic             viol_flag_r;
  logic [15:0]      viol_addr_r;

  assign sel_s = ({1'b0, bus.MAB} >= BASE_X) && ({1'b0, bus.MAB} < LIMIT_X);
  assign off_s = bus.MAB - BASE;
  assign idx_s = off_s[IDX_W:1];

  // FSM state and fill-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic: sweep every word once, then stay ready until reset.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_CLEAR: begin
        cnt_nxt_s = cnt_r + {{(IDX_W-1){1'b0}}, 1'b1};
        if (cnt_r == IDX_W'(SIZE_WORDS - 1)) begin
          state_nxt_s = ST_READY;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_READY: begin
        state_nxt_s = ST_READY;
      end
      default: begin
        state_nxt_s = ST_CLEAR;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  assign busy = (state_r == ST_CLEAR);

  // Write steering: the fill owns the RAM while clearing; CPU writes otherwise.
  always_comb begin
    we_lo_s = 1'b0;
    we_hi_s = 1'b0;
    widx_s  = idx_s;
    wdata_s = 16'h0000;
    if (state_r == ST_CLEAR) begin
      we_lo_s = 1'b1;
      we_hi_s = 1'b1;
      widx_s  = cnt_r;
    end else if (bus.MW && sel_s) begin
      if (bus.BW == WORD) begin
        we_lo_s = 1'b1;
        we_hi_s = 1'b1;
        wdata_s = bus.MDBout;
      end else begin
        we_lo_s = ~bus.MAB[0];
        we_hi_s = bus.MAB[0];
        wdata_s = lane_place(bus.MAB[0], bus.MDBout[7:0]);
      end
    end else begin
      wdata_s = 16'h0000;
    end
  end

  data_mem_responder_ram_word_array #(
    .WORDS (SIZE_WORDS),
    .IDX_W (IDX_W)
  ) u_ram_word_array (
    .clk   (clk),
    .we_lo (we_lo_s),
    .we_hi (we_hi_s),
    .widx  (widx_s),
    .wdata (wdata_s),
    .ridx  (idx_s),
    .rdata (rdata_s)
  );

  // Read data is forced to zero when not ours so responders can be OR-ed.
  always_comb begin
    mdbin_s = 16'h0000;
    if (!bus.MW && sel_s && (state_r == ST_READY)) begin
      if (bus.BW == BYTE) begin
        mdbin_s = bus.MAB[0] ? {8'h00, rdata_s[15:8]} : {8'h00, rdata_s[7:0]};
      end else begin
        mdbin_s = rdata_s;
      end
    end else begin
      mdbin_s = 16'h0000;
    end
  end

  assign bus.MDBin = mdbin_s;

  assign viol_s = bus.MW && sel_s && busy;

  // Sticky violation flag; a clear coinciding with a violation re-arms the address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      viol_flag_r <= 1'b0;
      viol_addr_r <= 16'h0000;
    end else if (viol_s) begin
      viol_flag_r <= 1'b1;
      if (!viol_flag_r || ViolClr) begin
        viol_addr_r <= bus.MAB;
      end
    end else if (ViolClr) begin
      viol_flag_r <= 1'b0;
    end
  end

  assign ViolFlag = viol_flag_r;
  assign ViolAddr = viol_addr_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised bench with a behavioural memory model plus directed literal checks.
module tb_data_mem_responder;
  import data_mem_responder_pkg::*;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic clr_a = 1'b0;
  logic clr_b = 1'b0;
  logic busy_a, flag_a, busy_b, flag_b;
  logic [15:0] addr_a, addr_b;

  data_mem_responder_if bus_a();
  data_mem_responder_if bus_b();

  data_mem_responder #(.BASE(16'h0200), .SIZE_WORDS(256), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst_a), .bus(bus_a), .ViolClr(clr_a),
    .busy(busy_a), .ViolFlag(flag_a), .ViolAddr(addr_a));

  data_mem_responder #(.BASE(16'h0200), .SIZE_WORDS(256), .CLEAR_ON_RESET(1'b0)) dut_nc (
    .clk(clk), .rst(rst_b), .bus(bus_b), .ViolClr(clr_b),
    .busy(busy_b), .ViolFlag(flag_b), .ViolAddr(addr_b));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model of dut (window 0x0200..0x03FF) ----
  int          clear_left;
  logic [15:0] m_mem [256];
  logic        m_flag;
  logic [15:0] m_addr;

  function automatic bit in_win(input logic [15:0] a);
    return (int'(a) >= 32'h0200) && (int'(a) < 32'h0400);
  endfunction

  function automatic int widx(input logic [15:0] a);
    return (int'(a) - 32'h0200) / 2;
  endfunction

  function automatic logic [15:0] exp_mdbin();
    logic [15:0] w;
    if (bus_a.MW || !in_win(bus_a.MAB) || clear_left > 0) return 16'h0000;
    w = m_mem[widx(bus_a.MAB)];
    if (bus_a.BW == WORD) return w;
    return bus_a.MAB[0] ? {8'h00, w[15:8]} : {8'h00, w[7:0]};
  endfunction

  // Model update on each clock edge, restarted by reset.
  always @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      clear_left <= 256;
      m_flag     <= 1'b0;
      m_addr     <= 16'h0000;
    end else begin
      if (bus_a.MW && in_win(bus_a.MAB) && clear_left > 0) begin
        m_flag <= 1'b1;
        if (!m_flag || clr_a) m_addr <= bus_a.MAB;
      end else if (clr_a) begin
        m_flag <= 1'b0;
      end
      if (bus_a.MW && in_win(bus_a.MAB) && clear_left == 0) begin
        if (bus_a.BW == WORD) m_mem[widx(bus_a.MAB)] <= bus_a.MDBout;
        else if (bus_a.MAB[0]) m_mem[widx(bus_a.MAB)][15:8] <= bus_a.MDBout[7:0];
        else m_mem[widx(bus_a.MAB)][7:0] <= bus_a.MDBout[7:0];
      end
      if (clear_left > 0) begin
        clear_left <= clear_left - 1;
        if (clear_left == 1) begin
          for (int i = 0; i < 256; i++) m_mem[i] <= 16'h0000;
        end
      end
    end
  end

  // Compare process: every cycle, midway between edges.
  always @(negedge clk) begin
    #2;
    if (chk_en && !rst_a) begin
      chk("busy", {31'd0, busy_a}, {31'd0, clear_left > 0});
      chk("viol_flag", {31'd0, flag_a}, {31'd0, m_flag});
      chk("viol_addr", {16'd0, addr_a}, {16'd0, m_addr});
      chk("mdbin", {16'd0, bus_a.MDBin}, {16'd0, exp_mdbin()});
    end
  end

  task automatic set_a(input logic [15:0] mab, input logic [15:0] dout,
                       input logic bw, input logic mw, input logic clr);
    bus_a.MAB = mab; bus_a.MDBout = dout; bus_a.BW = bw; bus_a.MW = mw; clr_a = clr;
  endtask

  task automatic set_b(input logic [15:0] mab, input logic [15:0] dout,
                       input logic bw, input logic mw);
    bus_b.MAB = mab; bus_b.MDBout = dout; bus_b.BW = bw; bus_b.MW = mw;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [15:0] a, d;
    logic bw, mw;
    set_a(16'h0000, 16'h0000, WORD, 1'b0, 1'b0);
    set_b(16'h0000, 16'h0000, WORD, 1'b0);

    // Reset state and clear latency.
    repeat (3) @(negedge clk);
    #3;
    chk("rst_busy", {31'd0, busy_a}, 32'd1);
    chk("rst_flag", {31'd0, flag_a}, 32'd0);
    chk("rst_addr", {16'd0, addr_a}, 32'h0000);
    chk("rst_nc_busy", {31'd0, busy_b}, 32'd0);
    @(negedge clk);
    rst_a = 1'b0;
    chk_en = 1'b1;
    n = 0;
    while (busy_a === 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("clear_cycles", n, 32'd256);
    set_a(16'h0200, 16'h0000, WORD, 1'b0, 1'b0); #3;
    chk("read_after_clear", {16'd0, bus_a.MDBin}, 32'h0000);
    chk("flag_after_clear", {31'd0, flag_a}, 32'd0);
    @(negedge clk);

    // Word and byte-lane access.
    set_a(16'h0204, 16'hBEEF, WORD, 1'b1, 1'b0); #3;
    chk("mdbin_during_write", {16'd0, bus_a.MDBin}, 32'h0000);
    @(negedge clk);
    set_a(16'h0204, 16'h0000, WORD, 1'b0, 1'b0); #3;
    chk("word_read_beef", {16'd0, bus_a.MDBin}, 32'hBEEF);
    @(negedge clk);
    set_a(16'h0205, 16'h0012, BYTE, 1'b1, 1'b0);
    @(negedge clk);
    set_a(16'h0204, 16'h0000, WORD, 1'b0, 1'b0); #3;
    chk("merged_word", {16'd0, bus_a.MDBin}, 32'h12EF);
    @(negedge clk);
    set_a(16'h0205, 16'h0000, BYTE, 1'b0, 1'b0); #3;
    chk("byte_read_hi", {16'd0, bus_a.MDBin}, 32'h0012);
    @(negedge clk);
    set_a(16'h0204, 16'h0000, BYTE, 1'b0, 1'b0); #3;
    chk("byte_read_lo", {16'd0, bus_a.MDBin}, 32'h00EF);
    @(negedge clk);

    // Window edges.
    set_a(16'h0400, 16'h0000, WORD, 1'b0, 1'b0); #3;
    chk("read_above", {16'd0, bus_a.MDBin}, 32'h0000);
    @(negedge clk);
    set_a(16'h01FE, 16'hFFFF, WORD, 1'b1, 1'b0);
    @(negedge clk);
    set_a(16'h0400, 16'hFFFF, WORD, 1'b1, 1'b0);
    @(negedge clk);
    set_a(16'h0200, 16'h0000, WORD, 1'b0, 1'b0); #3;
    chk("base_unchanged", {16'd0, bus_a.MDBin}, 32'h0000);
    @(negedge clk);
    set_a(16'h03FF, 16'h00AB, BYTE, 1'b1, 1'b0);
    @(negedge clk);
    set_a(16'h03FE, 16'h0000, WORD, 1'b0, 1'b0); #3;
    chk("last_word", {16'd0, bus_a.MDBin}, 32'hAB00);
    @(negedge clk);
    set_a(16'h0000, 16'h0000, WORD, 1'b0, 1'b0);

    // Responder without clear: ready at once, contents survive reset.
    rst_b = 1'b0;
    #3;
    chk("nc_busy", {31'd0, busy_b}, 32'd0);
    @(negedge clk);
    set_b(16'h0300, 16'h5A5A, WORD, 1'b1);
    @(negedge clk);
    set_b(16'h0300, 16'h0000, WORD, 1'b0); #3;
    chk("nc_read", {16'd0, bus_b.MDBin}, 32'h5A5A);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    rst_b = 1'b0; #3;
    chk("nc_busy_after_rst", {31'd0, busy_b}, 32'd0);
    chk("nc_read_after_rst", {16'd0, bus_b.MDBin}, 32'h5A5A);
    chk("nc_flag", {31'd0, flag_b}, 32'd0);
    @(negedge clk);

    // Violations during a fresh clear, then reset at cnt = 100.
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    set_a(16'h0210, 16'h1111, WORD, 1'b1, 1'b0); #3;
    chk("busy_in_clear", {31'd0, busy_a}, 32'd1);
    @(negedge clk);
    set_a(16'h0220, 16'h2222, WORD, 1'b1, 1'b0); #3;
    chk("viol1_flag", {31'd0, flag_a}, 32'd1);
    chk("viol1_addr", {16'd0, addr_a}, 32'h0210);
    @(negedge clk);
    set_a(16'h0000, 16'h0000, WORD, 1'b0, 1'b1); #3;
    chk("viol2_addr_held", {16'd0, addr_a}, 32'h0210);
    @(negedge clk);
    set_a(16'h0230, 16'h3333, WORD, 1'b1, 1'b1); #3;
    chk("violclr_flag", {31'd0, flag_a}, 32'd0);
    @(negedge clk);
    set_a(16'h0000, 16'h0000, WORD, 1'b0, 1'b0); #3;
    chk("viol3_flag", {31'd0, flag_a}, 32'd1);
    chk("viol3_addr", {16'd0, addr_a}, 32'h0230);
    repeat (96) @(negedge clk);
    chk("busy_at_cnt100", {31'd0, busy_a}, 32'd1);
    rst_a = 1'b1; #3;
    chk("midclear_rst_flag", {31'd0, flag_a}, 32'd0);
    @(negedge clk);
    rst_a = 1'b0;
    n = 0;
    while (busy_a === 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("reclear_cycles", n, 32'd256);
    set_a(16'h0210, 16'h0000, WORD, 1'b0, 1'b0); #3;
    chk("dropped_write", {16'd0, bus_a.MDBin}, 32'h0000);
    @(negedge clk);

    // Randomised traffic around the window, with one reset mid-way.
    for (int i = 0; i < 2000; i++) begin
      if (i == 700) begin
        rst_a = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_a = 1'b0;
      end
      a  = 16'($urandom_range(32'h01F0, 32'h0410));
      bw = 1'($urandom_range(0, 1));
      mw = ($urandom_range(0, 2) == 0);
      d  = 16'($urandom);
      if (bw == WORD) a[0] = 1'b0;
      else d[15:8] = 8'h00;
      set_a(a, d, bw, mw, ($urandom_range(0, 7) == 0));
      @(negedge clk);
    end
    set_a(16'h0000, 16'h0000, WORD, 1'b0, 1'b0);
    @(negedge clk);
    #4;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
